// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency memory port between instruction fetch and load/store.
// Define MEM_PORT_ARB_STATS_EN to add grant and conflict counters.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned XLEN        = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic [XLEN-1:0] if_data_o,
  output logic            if_ack_o,
  input  logic [1:0]      d_cmd_i,
  input  logic [XLEN-1:0] d_addr_i,
  input  logic [XLEN-1:0] d_wdata_i,
  output logic [XLEN-1:0] d_rdata_o,
  output logic            d_ack_o,
  output logic            if_stall_o,
  output logic            d_stall_o,
  output logic [1:0]      mem_cmd_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
`ifdef MEM_PORT_ARB_STATS_EN
  output logic [15:0]     stat_if_grants_o,
  output logic [15:0]     stat_d_grants_o,
  output logic [15:0]     stat_conflicts_o,
`endif
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam logic [1:0] BusNone  = 2'd0;
  localparam logic [1:0] BusLoad  = 2'd1;
  localparam logic [1:0] BusStore = 2'd2;
  localparam logic [3:0] CntInit  = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;
  typedef enum logic {OwnIf, OwnD} owner_e;

  state_e          state_q;
  owner_e          owner_q, last_grant_q;
  logic [3:0]      cnt_q;
  logic [1:0]      mem_cmd_q;
  logic [XLEN-1:0] mem_addr_q, mem_wdata_q, if_data_q, d_rdata_q;
  logic            if_ack_q, d_ack_q;

  logic d_valid, grant_d, grant_if;

  // Code 3 is not a real command and is ignored like BusNone.
  always_comb begin
    d_valid  = (d_cmd_i == BusLoad) || (d_cmd_i == BusStore);
    grant_d  = 1'b0;
    grant_if = 1'b0;
    if (state_q == StIdle) begin
      grant_d  = d_valid && (!if_req_i || (last_grant_q == OwnIf));
      grant_if = if_req_i && !grant_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      owner_q      <= OwnIf;
      last_grant_q <= OwnIf;
      cnt_q        <= '0;
      mem_cmd_q    <= BusNone;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_data_q    <= '0;
      d_rdata_q    <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_d) begin
            mem_cmd_q    <= d_cmd_i;
            mem_addr_q   <= d_addr_i;
            mem_wdata_q  <= d_wdata_i;
            owner_q      <= OwnD;
            last_grant_q <= OwnD;
            cnt_q        <= CntInit;
            state_q      <= StBusy;
          end else if (grant_if) begin
            mem_cmd_q    <= BusLoad;
            mem_addr_q   <= if_addr_i;
            mem_wdata_q  <= '0;
            owner_q      <= OwnIf;
            last_grant_q <= OwnIf;
            cnt_q        <= CntInit;
            state_q      <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q == 4'd0) begin
            if (mem_cmd_q == BusLoad) begin
              if (owner_q == OwnD) d_rdata_q <= mem_rdata_i;
              else                 if_data_q <= mem_rdata_i;
            end
            // Ack is registered here so it lands exactly on the response cycle.
            if (owner_q == OwnD) d_ack_q  <= 1'b1;
            else                 if_ack_q <= 1'b1;
            mem_cmd_q <= BusNone;
            state_q   <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef MEM_PORT_ARB_STATS_EN
  logic [15:0] stat_if_grants_q, stat_d_grants_q, stat_conflicts_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_if_grants_q <= '0;
      stat_d_grants_q  <= '0;
      stat_conflicts_q <= '0;
    end else begin
      if (grant_if) stat_if_grants_q <= stat_if_grants_q + 16'd1;
      if (grant_d)  stat_d_grants_q  <= stat_d_grants_q + 16'd1;
      if ((state_q == StIdle) && d_valid && if_req_i) begin
        stat_conflicts_q <= stat_conflicts_q + 16'd1;
      end
    end
  end

  assign stat_if_grants_o = stat_if_grants_q;
  assign stat_d_grants_o  = stat_d_grants_q;
  assign stat_conflicts_o = stat_conflicts_q;
`endif

  assign if_data_o   = if_data_q;
  assign if_ack_o    = if_ack_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_ack_o     = d_ack_q;
  assign mem_cmd_o   = mem_cmd_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_stall_o  = if_req_i & ~if_ack_q;
  assign d_stall_o   = d_valid & ~d_ack_q;

endmodule
